fir_coe_reload_ctrl: RTL

Read-side consumer for FIR coefficient sets stored in DDR. On a reload request, it issues read commands on the channel-0 coefficient read port (`ddr_rd0_en`/`ddr_rd0_addr`) and collects the returned `readback0_*` word stream. It forwards each word as an indexed tap write into the FIR shadow coefficient bank, then emits a single swap pulse so the FIR engine switches banks atomically. Timeout and length checks guarantee the FIR never swaps in a partial set.

---
 rtl/fir_coe_pkg.sv | 30 +++
 rtl/fir_coe_chksum.sv | 45 ++++
 rtl/fir_coe_reload_ctrl.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/fir_coe_pkg.sv
// fir_coe_pkg: shared types and constants for the FIR coefficient reload path.
//   state_e         reload controller states
//   ERR_*           err_code encodings
//   REQ_NUM         read commands per set for the default geometry
//   req_num()       same quantity for an arbitrary geometry
package fir_coe_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        CHECK,
        SWAP,
        ERR
    } state_e;

    localparam logic [1:0] ERR_NONE = 2'd0;
    localparam logic [1:0] ERR_TMO  = 2'd1;
    localparam logic [1:0] ERR_LEN  = 2'd2;
    localparam logic [1:0] ERR_CHK  = 2'd3;

    localparam int TAP_NUM_DEF       = 32;
    localparam int WORDS_PER_REQ_DEF = 32;
    localparam int REQ_NUM           = TAP_NUM_DEF / WORDS_PER_REQ_DEF;

    function automatic int req_num(input int tap_num, input int words_per_req);
        return tap_num / words_per_req;
    endfunction

endpackage

// File: rtl/fir_coe_chksum.sv
// fir_coe_chksum: 32-bit modulo sum of accepted coefficient words, compared
// against an expected value captured at clear time.
//   clk, rst_n  clock and async active-low reset
//   clr         zero the sum and capture exp_in
//   add         accumulate add_data this cycle
//   match       sum equals the captured expected value
module fir_coe_chksum
    import fir_coe_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        add,
    input  logic [31:0] add_data,
    input  logic [31:0] exp_in,
    output logic        match
);

    logic [31:0] sum_q, sum_d;
    logic [31:0] exp_q, exp_d;

    always_comb begin
        sum_d = sum_q;
        exp_d = exp_q;
        if (clr) begin
            sum_d = '0;
            exp_d = exp_in;
        end else if (add) begin
            sum_d = sum_q + add_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q <= '0;
            exp_q <= '0;
        end else begin
            sum_q <= sum_d;
            exp_q <= exp_d;
        end
    end

    assign match = (sum_q == exp_q);

endmodule

// File: rtl/fir_coe_reload_ctrl.sv
// fir_coe_reload_ctrl: fetches one FIR coefficient set from DDR, writes it into
// the shadow bank tap by tap, then pulses coe_swap once the full set is in.
// Optional build macro: FIR_COE_CHKSUM_EN adds a checksum gate before the swap.
//   reload_req/reload_set/chk_expect   start pulse, set index, expected sum
//   ddr_rd0_en/ddr_rd0_addr            read command to DDR
//   readback0_vld/last/data            returned word stream
//   coe_wr_vld/idx/data                shadow-bank tap write
//   coe_swap, busy, done, err, err_code status
//
// state | meaning
// IDLE  | waiting for reload_req
// REQ   | issuing one read command
// WAIT  | collecting words of the current command, timeout running
// CHECK | full set received, checksum decision
// SWAP  | coe_swap/done pulse
// ERR   | abort, err raised, no swap
module fir_coe_reload_ctrl
    import fir_coe_pkg::*;
#(
    parameter int          TAP_NUM       = 32,
    parameter int          COE_WD        = 32,
    parameter int          WORDS_PER_REQ = 32,
    parameter logic [31:0] REQ_ADDR_STEP = 32'h80,
    parameter logic [31:0] SET_ADDR_STEP = 32'h1000,
    parameter int          TIMEOUT_CYC   = 4096
) (
    input  logic                       rd_clk,
    input  logic                       rd_rst_n,
    input  logic                       reload_req,
    input  logic [3:0]                 reload_set,
    input  logic [31:0]                chk_expect,
    output logic                       ddr_rd0_en,
    output logic [31:0]                ddr_rd0_addr,
    input  logic                       readback0_vld,
    input  logic                       readback0_last,
    input  logic [COE_WD-1:0]          readback0_data,
    output logic                       coe_wr_vld,
    output logic [$clog2(TAP_NUM)-1:0] coe_wr_idx,
    output logic [COE_WD-1:0]          coe_wr_data,
    output logic                       coe_swap,
    output logic                       busy,
    output logic                       done,
    output logic                       err,
    output logic [1:0]                 err_code
);

    localparam int IDX_W = $clog2(TAP_NUM);
    localparam int N_REQ = req_num(TAP_NUM, WORDS_PER_REQ);
    localparam int RC_W  = $clog2(N_REQ + 1);
    localparam int CC_W  = $clog2(WORDS_PER_REQ + 2);
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

    localparam logic [RC_W-1:0]  RC_LAST  = RC_W'(N_REQ - 1);
    localparam logic [CC_W-1:0]  WPR_C    = CC_W'(WORDS_PER_REQ);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

    state_e              state_q, state_d;
    logic [31:0]         base_q, base_d;
    logic [RC_W-1:0]     req_cnt_q, req_cnt_d;
    logic [CC_W-1:0]     cmd_cnt_q, cmd_cnt_d;
    logic [IDX_W-1:0]    word_cnt_q, word_cnt_d;
    logic [TMO_W-1:0]    tmo_q, tmo_d;
    logic                wr_vld_q, wr_vld_d;
    logic [IDX_W-1:0]    wr_idx_q, wr_idx_d;
    logic [COE_WD-1:0]   wr_data_q, wr_data_d;
    logic                err_q, err_d;
    logic [1:0]          err_code_q, err_code_d;
    logic [CC_W-1:0]     cmd_words;
    logic                chk_clr, chk_add, chk_match;

    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        req_cnt_d  = req_cnt_q;
        cmd_cnt_d  = cmd_cnt_q;
        word_cnt_d = word_cnt_q;
        tmo_d      = tmo_q;
        wr_vld_d   = 1'b0;
        wr_idx_d   = wr_idx_q;
        wr_data_d  = wr_data_q;
        err_d      = err_q;
        err_code_d = err_code_q;
        chk_clr    = 1'b0;
        chk_add    = 1'b0;
        cmd_words  = cmd_cnt_q + 1'b1;

        case (state_q)
            IDLE: begin
                if (reload_req) begin
                    state_d    = REQ;
                    base_d     = 32'(reload_set) * SET_ADDR_STEP;
                    req_cnt_d  = '0;
                    word_cnt_d = '0;
                    err_d      = 1'b0;
                    err_code_d = ERR_NONE;
                    chk_clr    = 1'b1;
                end
            end
            REQ: begin
                tmo_d     = '0;
                cmd_cnt_d = '0;
                state_d   = WAIT;
            end
            WAIT: begin
                tmo_d = tmo_q + 1'b1;
                if (readback0_vld) begin
                    wr_vld_d   = 1'b1;
                    wr_idx_d   = word_cnt_q;
                    wr_data_d  = readback0_data;
                    word_cnt_d = word_cnt_q + 1'b1;
                    cmd_cnt_d  = cmd_words;
                    chk_add    = 1'b1;
                    if (readback0_last) begin
                        if (cmd_words == WPR_C) begin
                            if (req_cnt_q == RC_LAST) begin
                                state_d = CHECK;
                            end else begin
                                state_d   = REQ;
                                req_cnt_d = req_cnt_q + 1'b1;
                            end
                        end else begin
                            state_d    = ERR;
                            err_d      = 1'b1;
                            err_code_d = ERR_LEN;
                        end
                    end else if (cmd_words > WPR_C) begin
                        state_d    = ERR;
                        err_d      = 1'b1;
                        err_code_d = ERR_LEN;
                    end
                end
                // Decided one cycle early so err lands exactly TIMEOUT_CYC
                // cycles after the command; a word in this cycle takes priority.
                if (state_d == WAIT && tmo_d == TMO_LAST) begin
                    state_d    = ERR;
                    err_d      = 1'b1;
                    err_code_d = ERR_TMO;
                end
            end
            CHECK: begin
                if (chk_match) begin
                    state_d = SWAP;
                end else begin
                    state_d    = ERR;
                    err_d      = 1'b1;
                    err_code_d = ERR_CHK;
                end
            end
            SWAP:    state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge rd_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
            state_q    <= IDLE;
            base_q     <= '0;
            req_cnt_q  <= '0;
            cmd_cnt_q  <= '0;
            word_cnt_q <= '0;
            tmo_q      <= '0;
            wr_vld_q   <= 1'b0;
            wr_idx_q   <= '0;
            wr_data_q  <= '0;
            err_q      <= 1'b0;
            err_code_q <= ERR_NONE;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            req_cnt_q  <= req_cnt_d;
            cmd_cnt_q  <= cmd_cnt_d;
            word_cnt_q <= word_cnt_d;
            tmo_q      <= tmo_d;
            wr_vld_q   <= wr_vld_d;
            wr_idx_q   <= wr_idx_d;
            wr_data_q  <= wr_data_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
        end
    end

`ifdef FIR_COE_CHKSUM_EN
    fir_coe_chksum u_chksum (
        .clk      (rd_clk),
        .rst_n    (rd_rst_n),
        .clr      (chk_clr),
        .add      (chk_add),
        .add_data (readback0_data),
        .exp_in   (chk_expect),
        .match    (chk_match)
    );
`else
    logic unused_chk;
    assign unused_chk = ^{chk_expect, chk_clr, chk_add};
    assign chk_match  = 1'b1;
`endif

    assign ddr_rd0_en   = (state_q == REQ);
    assign ddr_rd0_addr = ddr_rd0_en ? (base_q + 32'(req_cnt_q) * REQ_ADDR_STEP) : 32'h0;
    assign coe_wr_vld   = wr_vld_q;
    assign coe_wr_idx   = wr_idx_q;
    assign coe_wr_data  = wr_data_q;
    assign coe_swap     = (state_q == SWAP);
    assign done         = (state_q == SWAP);
    // SWAP and ERR are the terminating cycles, so busy is already low there.
    assign busy         = (state_q == REQ) || (state_q == WAIT) || (state_q == CHECK);
    assign err          = err_q;
    assign err_code     = err_code_q;

endmodule
